// File: rtl/apb_regfile_mc_if.sv
// APB slave-side bus bundle for the multi-channel GCD register file.
interface apb_regfile_mc_if;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regfile_mc.sv
// Multi-channel APB register file driving NUM_CH GCD engines: per-channel
// control/command/status, W1C interrupt aggregation and optional wait states.
module apb_regfile_mc #(
    parameter int NUM_CH      = 4,
    parameter int OPCODE_W    = 3,
    parameter int COUNT_W     = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    apb_regfile_mc_if.slave              apb,
    output logic [NUM_CH-1:0]            CONSTANT_TIME,
    output logic [NUM_CH-1:0]            START_PULSE,
    output logic [NUM_CH*OPCODE_W-1:0]   OPCODE,
    output logic [NUM_CH*COUNT_W-1:0]    CYCLE_COUNT,
    input  logic [NUM_CH-1:0]            DONE_PULSE,
    output logic                         IRQ
);

    logic [1:0]        wait_cnt;
    logic              setup_ph;
    logic              access_ph;
    logic              ready;
    logic              complete;
    logic              addr_ok;
    logic              glob_space;
    logic              chan_space;
    logic [1:0]        reg_sel;
    logic [3:0]        ch_sel;
    logic [NUM_CH-1:0] ch_hit;
    logic              any_ch;
    logic              sel_busy;
    logic              cmd_start;
    logic              wr_bad;
    logic              access_err;
    logic              wr_ok;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] start_ev;
    logic [NUM_CH-1:0] ctrl_we;
    logic [NUM_CH-1:0] done_ev;
    logic [NUM_CH-1:0] w1c;
    logic [NUM_CH-1:0] irq_status;
    logic [NUM_CH-1:0] irq_enable;
    logic              gctrl;
    logic [7:0]        done_cnt [NUM_CH];
    logic [31:0]       rdata;
    logic              unused_bits;

    assign setup_ph  = apb.PSEL & ~apb.PENABLE;
    assign access_ph = apb.PSEL & apb.PENABLE;
    assign ready     = ~(access_ph && (wait_cnt != 2'd0));
    assign complete  = access_ph & ready;

    assign addr_ok    = (apb.PADDR[31:12] == 20'd0);
    assign glob_space = addr_ok && (apb.PADDR[11:4] == 8'd0);
    assign chan_space = addr_ok && (apb.PADDR[11:8] == 4'h1) && (apb.PADDR[3:2] != 2'd3);
    assign reg_sel    = apb.PADDR[3:2];
    assign ch_sel     = apb.PADDR[7:4];

    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    // Channel select: one-hot hit for an implemented channel register
    always_comb begin
        ch_hit = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ch_hit[n] = chan_space && (ch_sel == 4'(n));
        end
    end

    assign any_ch    = |ch_hit;
    assign sel_busy  = |(ch_hit & busy);
    assign cmd_start = any_ch && (reg_sel == 2'd1) && apb.PWDATA[0];
    assign wr_bad    = (glob_space && (reg_sel == 2'd0))
                     || (any_ch && (reg_sel == 2'd2))
                     || (any_ch && (reg_sel == 2'd0) && sel_busy)
                     || (cmd_start && sel_busy);
    assign access_err = !(glob_space || any_ch) || (apb.PWRITE && wr_bad);
    assign wr_ok      = complete && apb.PWRITE && !access_err;

    assign start_ev = (wr_ok && cmd_start) ? ch_hit : '0;
    assign ctrl_we  = (wr_ok && any_ch && (reg_sel == 2'd0)) ? ch_hit : '0;
    assign done_ev  = DONE_PULSE & busy;
    assign w1c      = (wr_ok && glob_space && (reg_sel == 2'd1)) ? apb.PWDATA[NUM_CH-1:0] : '0;

    // Read multiplexer; only meaningful on a good completing cycle
    always_comb begin
        rdata = 32'd0;
        if (glob_space) begin
            case (reg_sel)
                2'd0:    rdata = {16'h0001, 8'h00, 8'(NUM_CH)};
                2'd1:    rdata[NUM_CH-1:0] = irq_status;
                2'd2:    rdata[NUM_CH-1:0] = irq_enable;
                default: rdata[0] = gctrl;
            endcase
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_hit[n] && (reg_sel == 2'd0)) begin
                rdata[0]              = CONSTANT_TIME[n];
                rdata[4 +: OPCODE_W]  = OPCODE[n*OPCODE_W +: OPCODE_W];
                rdata[16 +: COUNT_W]  = CYCLE_COUNT[n*COUNT_W +: COUNT_W];
            end else if (ch_hit[n] && (reg_sel == 2'd2)) begin
                rdata[0]    = busy[n];
                rdata[15:8] = done_cnt[n];
            end
        end
    end

    assign apb.PREADY  = ready;
    assign apb.PRDATA  = (complete && !access_err) ? rdata : 32'd0;
    assign apb.PSLVERR = complete && access_err;

    // Wait-state counter: loaded in setup, counts down through the access phase
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wait_cnt <= 2'd0;
        end else if (setup_ph) begin
            wait_cnt <= 2'(WAIT_CYCLES);
        end else if (access_ph && (wait_cnt != 2'd0)) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // Per-channel control fields, writable only while the channel is idle
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            CONSTANT_TIME <= '0;
            OPCODE        <= '0;
            CYCLE_COUNT   <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ctrl_we[n]) begin
                    CONSTANT_TIME[n]                  <= apb.PWDATA[0];
                    OPCODE[n*OPCODE_W +: OPCODE_W]    <= apb.PWDATA[4 +: OPCODE_W];
                    CYCLE_COUNT[n*COUNT_W +: COUNT_W] <= apb.PWDATA[16 +: COUNT_W];
                end
            end
        end
    end

    // Channel lifecycle: start sets busy and fires one pulse, done clears busy and counts
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            busy        <= '0;
            START_PULSE <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                done_cnt[n] <= 8'd0;
            end
        end else begin
            busy        <= (busy & ~done_ev) | start_ev;
            START_PULSE <= start_ev;
            for (int n = 0; n < NUM_CH; n++) begin
                if (done_ev[n]) begin
                    done_cnt[n] <= done_cnt[n] + 8'd1;
                end
            end
        end
    end

    // Interrupt state: hardware set beats a same-cycle W1C; IRQ output lags by one cycle
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            irq_status <= '0;
            irq_enable <= '0;
            gctrl      <= 1'b0;
            IRQ        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~w1c) | done_ev;
            if (wr_ok && glob_space && (reg_sel == 2'd2)) begin
                irq_enable <= apb.PWDATA[NUM_CH-1:0];
            end
            if (wr_ok && glob_space && (reg_sel == 2'd3)) begin
                gctrl <= apb.PWDATA[0];
            end
            IRQ <= gctrl & (|(irq_status & irq_enable));
        end
    end

endmodule
